// File: rtl/mem_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_ctrl
// Brief    : Single-outstanding load/store initiator toward the 16-bit memory
//            interface with overflow detection, wait timeout and error count.
//            Optional macro MEM_REQ_PRECHECK_EN checks overflow on req_addr in IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module mem_request_ctrl #(
    parameter int WIDE    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_rw,
    input  logic [WIDE-1:0] req_addr,
    input  logic [WIDE-1:0] req_wdata,
    output logic            resp_valid,
    output logic [WIDE-1:0] resp_rdata,
    output logic            resp_err,
    output logic            resp_timeout,
    output logic            mem_req,
    output logic [WIDE-1:0] mem_address,
    output logic [WIDE-1:0] mem_wdata,
    output logic            mem_rw,
    input  logic            mem_valid,
    input  logic [WIDE-1:0] mem_rdata,
    input  logic            mem_overflow,
    output logic [7:0]      err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] C_WAIT_LIMIT = 8'(TIMEOUT - 1);
    localparam logic [7:0] C_ERR_MAX    = 8'hFF;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_wait_cnt;
    logic [7:0]      r_err_count;
    logic            r_err;
    logic            r_timeout;
    logic            r_rw;
    logic [WIDE-1:0] r_addr;
    logic [WIDE-1:0] r_wdata;
    logic [WIDE-1:0] r_rdata;

    logic            w_accept;
    logic            w_mem_req;
    logic            w_issue_ovf;
    logic            w_limit_hit;
    logic            w_req_ovf;

`ifdef MEM_REQ_PRECHECK_EN
    // Overflow is decided from the request itself; the memory-side flag is unused.
    logic            w_unused_mem_ovf;
    assign w_req_ovf        = |req_addr[WIDE-1:12];
    assign w_issue_ovf      = 1'b0;
    assign w_unused_mem_ovf = mem_overflow;
`else
    assign w_req_ovf   = 1'b0;
    assign w_issue_ovf = mem_overflow;
`endif

    assign w_limit_hit = (r_wait_cnt == C_WAIT_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mem_req   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_req_ovf ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_issue_ovf) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_mem_req   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A completion on the limit cycle still wins over the timeout.
                if (mem_valid || w_limit_hit) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wait_cnt  <= 8'd0;
            r_err_count <= 8'd0;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_timeout <= 1'b0;
                        if (w_req_ovf) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err   <= 1'b0;
                            r_addr  <= req_addr;
                            r_wdata <= req_wdata;
                            r_rw    <= req_rw;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_issue_ovf) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        if (!r_rw) begin
                            r_rdata <= mem_rdata;
                        end
                        r_err     <= 1'b0;
                        r_timeout <= 1'b0;
                    end else if (w_limit_hit) begin
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (r_err && (r_err_count != C_ERR_MAX)) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
                default: begin
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign resp_valid   = (r_state == S_RESP);
    assign resp_rdata   = r_rdata;
    assign resp_err     = r_err;
    assign resp_timeout = r_timeout;
    assign mem_req      = w_mem_req;
    assign mem_address  = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_rw       = r_rw;
    assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: doc/mem_request_ctrl.md
Name: mem_request_ctrl

Overview:
- Processor-side initiator for the 16-bit memory interface: takes one load/store request at a time from the datapath and drives the address, write data and read/write select.
- Waits for the memory side's valid strobe and returns read data plus error status to the datapath.
- Handles address overflow (address[15:12] != 0) and a bounded wait timeout.
- Sits between the datapath/control unit and the memory interface; one outstanding transaction at most.

Parameters:
- WIDE, 16, data and address width
- TIMEOUT, 15, max cycles in WAIT before abort (1..255)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- req_valid  input  1  datapath request strobe
- req_ready  output  1  controller can accept a request
- req_rw  input  1  0 = READ, 1 = WRITE
- req_addr  input  WIDE  request address
- req_wdata  input  WIDE  store data
- resp_valid  output  1  one-cycle response strobe
- resp_rdata  output  WIDE  load data (valid with resp_valid on reads)
- resp_err  output  1  overflow or timeout on this transaction
- resp_timeout  output  1  timeout cause flag (valid with resp_valid)
- mem_req  output  1  one-cycle request pulse to memory side
- mem_address  output  WIDE  address to memory interface
- mem_wdata  output  WIDE  data to memory interface input bus
- mem_rw  output  1  read/write select to memory interface
- mem_valid  input  1  memory side completion strobe
- mem_rdata  input  WIDE  memory side output bus
- mem_overflow  input  1  memory side address overflow flag (combinational from mem_address)
- err_count  output  8  saturating count of errored transactions

Behaviour:
- Reset (reset_n low at rising edge): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; resp_timeout=0; mem_req=0; mem_address=0; mem_wdata=0; mem_rw=0 (READ); err_count=0; wait counter=0. Reset mid-transaction aborts it silently: no response is issued.
- req_ready=1 only in IDLE.
- IDLE: on req_valid && req_ready, register req_addr, req_wdata and req_rw into mem_address, mem_wdata and mem_rw, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_overflow=1: mem_req stays 0, the error is latched, go to RESP.
  - Otherwise: mem_req=1 for this cycle only, wait counter cleared, go to WAIT.
- WAIT:
  - mem_valid=1: capture mem_rdata into resp_rdata if mem_rw=READ (resp_rdata unchanged on WRITE), error cleared, go to RESP.
  - Else counter increments. When counter == TIMEOUT-1 with no mem_valid, latch error and timeout, go to RESP.
  - mem_valid arriving in the same cycle as the timeout limit counts as success.
- RESP (exactly 1 cycle):
  - resp_valid=1; resp_err and resp_timeout reflect the latched status.
  - err_count increments if resp_err, saturating at 255.
  - Next state IDLE.
- mem_address, mem_wdata and mem_rw are held stable from ISSUE through RESP.
- mem_valid outside WAIT is ignored.
- Latency, request accept to resp_valid: 3 cycles for a 1-cycle memory, 2 cycles for overflow; 2+TIMEOUT cycles worst case.
- Back-to-back: the next request can be accepted the cycle after RESP.
- req_* inputs are ignored while req_ready=0.

Optional Feature:
- Macro MEM_REQ_PRECHECK_EN.
- Defined: overflow is checked in IDLE on req_addr[15:12]. A non-zero value skips ISSUE and goes directly to RESP with resp_err=1. mem_address/mem_wdata/mem_rw are not updated, and mem_overflow is ignored.
- Undefined: overflow is detected only via mem_overflow in ISSUE, as above.

Test Plan:
- Read: reset, req READ addr 0x0123. Memory returns mem_valid one cycle after mem_req with mem_rdata 0xBEEF -> mem_req pulses once, mem_rw=0, resp_valid 3 cycles after accept, resp_rdata=0xBEEF, resp_err=0.
- Write: req WRITE addr 0x0FFF, wdata 0x5A5A -> mem_rw=1, mem_wdata=0x5A5A held through RESP, resp_err=0, resp_rdata unchanged.
- Overflow: req READ addr 0x1000 with mem_overflow=1 -> mem_req never asserts, resp_valid with resp_err=1, resp_timeout=0, err_count=1. With MEM_REQ_PRECHECK_EN, mem_address stays at the previous value.
- Timeout:
  - TIMEOUT=15, memory never responds -> resp_err=1, resp_timeout=1 exactly 17 cycles after accept; a late mem_valid afterwards is ignored.
  - Boundary: mem_valid on the limit cycle -> success.
- Saturation and reset: drive 260 overflowing requests -> err_count stops at 255. Assert reset_n=0 during WAIT -> no resp_valid, all outputs at reset values, req_ready=1 the next cycle.
